ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the PS/2 host request protocol. It is the outbound companion of the keyboard receive driver and runs on the 75 MHz VGA clock. It drives the open-drain PS2_CLK/PS2_DAT pads through active-high pull-low enables, and tells the receive path to ignore line activity while a frame is in flight.

## Interface
- INHIBIT_CYCLES, 7500: clock-low inhibit duration (100 µs at 75 MHz).
- TIMEOUT_CYCLES, 1125000: whole-frame limit from clock release to ack sample (15 ms).
- FILTER_LEN, 8: consecutive identical samples needed to accept a new pin level.
- clk  in  1  75 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- tx_valid  in  1  request to send tx_data.
- tx_data  in  8  command byte.
- tx_ready  out  1  high only in IDLE; transfer on tx_valid & tx_ready.
- done  out  1  one-cycle pulse at end of every accepted frame.
- err  out  1  valid with done: 1 = timeout or ack missing.
- busy  out  1  high from accept cycle until done; receiver ignores PS/2 while high.
- ps2_clk_in  in  1  raw PS2_CLK pad level.
- ps2_dat_in  in  1  raw PS2_DAT pad level.
- ps2_clk_drv_low  out  1  1 = pull PS2_CLK low, 0 = release.
- ps2_dat_drv_low  out  1  1 = pull PS2_DAT low, 0 = release.

## Operation
- Input conditioning per line: 2-FF synchronizer, then filter updates its output only after FILTER_LEN equal samples. Falling edge = filtered clock 1→0, single-cycle pulse.
- States: IDLE → INHIBIT → START → BITS → STOP → ACK → RECOVER → IDLE.
- IDLE: both drives 0. On accept: latch tx_data into shift register, compute parity = ~^tx_data (odd), bit counter = 0.
- INHIBIT: clk_drv_low = 1 for exactly INHIBIT_CYCLES cycles.
- START: clk_drv_low = 1 and dat_drv_low = 1 for one cycle (start bit 0); then clock released, data held low, timeout counter starts.
- BITS: on each falling edge drive next bit (dat_drv_low = ~bit): edges 1–8 data LSB first, edge 9 parity.
- STOP: edge 10 releases data (stop = 1).
- ACK: on edge 11 sample filtered data: 0 = ack ok, 1 = err.
- RECOVER: wait until filtered clock and data both high, then done pulse, return to IDLE.
- Timeout: counter reaching TIMEOUT_CYCLES in START-release/BITS/STOP/ACK/RECOVER → release both lines, done = 1, err = 1, IDLE next cycle.
- tx_valid while busy: ignored, not queued. tx_data only sampled on accept.
- Device-side byte response (0xFA) is received by the existing receive driver after busy drops; not this block's concern.

## Timing
- Reset values: tx_ready 1, done 0, err 0, busy 0, both drv_low 0, state IDLE, counters 0. Assertion of reset releases both lines immediately (asynchronous), including mid-frame.
- Accept at cycle T: busy and clk_drv_low high from T+1; INHIBIT spans T+1..T+INHIBIT_CYCLES; START at T+INHIBIT_CYCLES+1; clock released at T+INHIBIT_CYCLES+2.
- Bit update: dat_drv_low changes the cycle after the detected falling edge; edge detect lags pad by 2+FILTER_LEN cycles (well inside the ≥5 µs half-period).
- err registered together with done; holds value until next done.
- tx_ready re-asserts the cycle after done; back-to-back accept allowed then.

## Structure
- Shared package ps2_pkg: state enum, command constants (CMD_SET_LEDS 0xED, CMD_ENABLE 0xF4, CMD_RESET 0xFF), RESP_ACK 0xFA, default timing constants.
- Sub-module ps2_line_filter (synchronizer + stability filter + falling-edge pulse), instantiated for clock and data.
- Counters: inhibit 13 bits, timeout 21 bits, bit index 4 bits.

## Test plan
- Send 0xED to behavioural device (10 kHz clock, ack low): pad bits after start 1,0,1,1,0,1,1,1, parity 1, stop 1 → done=1, err=0.
- Send 0x00: eight 0 bits, parity 1; check INHIBIT clock-low width = 7500 cycles exactly.
- Device never clocks → done with err=1 exactly TIMEOUT_CYCLES after clock release; both lines released.
- Device leaves data high at edge 11 → done with err=1, no timeout.
- Assert reset during bit 4 → both drv_low 0 same cycle, tx_ready 1 after release; next 0xFF frame completes err=0.
- tx_valid held high across frame with data changing → exactly one frame per accept, each carrying the byte present at its accept cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes,
// default timing constants for a 75 MHz clock and counter widths.
// Frame helper builds the 9 bits shifted out after the start bit.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_START,
      ST_BITS,
      ST_STOP,
      ST_ACK,
      ST_RECOVER
   } ps2_state_t;

   // Host commands and the device acknowledge byte.
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] RESP_ACK     = 8'hFA;

   // Default timing at 75 MHz: 100 us inhibit, 15 ms frame limit.
   localparam int INHIBIT_CYCLES_DEF = 7500;
   localparam int TIMEOUT_CYCLES_DEF = 1125000;
   localparam int FILTER_LEN_DEF     = 8;

   localparam int INHIBIT_W = 13;
   localparam int TIMEOUT_W = 21;
   localparam int BIT_IDX_W = 4;

   // Data LSB first, then odd parity in bit 8.
   function automatic logic [8:0] ps2_frame_bits(input logic [7:0] b);
      return {~^b, b};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one PS/2 pad: 2-FF synchronizer, stability filter, falling-edge pulse.
// Latency: level follows the pad 2+FILTER_LEN cycles later; fall pulses with the 1->0 update.
// No backpressure: free-running sampler.
// Ports: clk, reset (async active-low), pad_in (raw pad), level (filtered), fall (1-cycle pulse).
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = FILTER_LEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic pad_in,
   output logic level,
   output logic fall
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt_q counts consecutive synchronized samples that disagree with the
   // current filtered level; any agreeing sample restarts the count.
   always_comb begin
      sync1_d = pad_in;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      fall_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            fall_d  = level_q & ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Idle PS/2 lines are pulled up, so everything resets to the high level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data + parity + stop, ack check.
// Latency: clock pulled low the cycle after accept; done ~11 device clocks after release.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is dropped, never queued.
// Ports: clk, reset (async active-low); tx_valid/tx_data/tx_ready request handshake;
//        done/err completion (err valid with done, held until next done); busy;
//        ps2_*_in raw pads; ps2_*_drv_low active-high open-drain pull-low enables.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       done,
   output logic       err,
   output logic       busy,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_drv_low,
   output logic       ps2_dat_drv_low
);

   localparam logic [INHIBIT_W-1:0] INHIBIT_LAST = INHIBIT_W'(INHIBIT_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   // Index of the device clock edge that carries parity (edges 1..8 are data).
   localparam logic [BIT_IDX_W-1:0] PARITY_IDX   = BIT_IDX_W'(8);

   ps2_state_t           state_q, state_d;
   logic [8:0]           shift_q, shift_d;
   logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [INHIBIT_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
   logic                 clk_drv_q, clk_drv_d;
   logic                 dat_drv_q, dat_drv_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 nack_q, nack_d;

   logic clk_level, clk_fall;
   logic dat_level;
   logic dat_fall_unused;   // data-line edges carry no meaning for the host
   logic accept;
   logic in_frame;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk    (clk),
      .reset  (reset),
      .pad_in (ps2_clk_in),
      .level  (clk_level),
      .fall   (clk_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
      .clk    (clk),
      .reset  (reset),
      .pad_in (ps2_dat_in),
      .level  (dat_level),
      .fall   (dat_fall_unused)
   );

   // Ready drops during the done cycle so a new request lands one cycle later.
   assign tx_ready = (state_q == ST_IDLE) && !done_q;
   assign busy     = !tx_ready;
   assign accept   = tx_valid && tx_ready;

   // Frame-limit window: from clock release until the lines recover.
   assign in_frame = (state_q == ST_BITS) || (state_q == ST_STOP) ||
                     (state_q == ST_ACK)  || (state_q == ST_RECOVER);

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      inh_cnt_d = inh_cnt_q;
      to_cnt_d  = to_cnt_q;
      clk_drv_d = clk_drv_q;
      dat_drv_d = dat_drv_q;
      done_d    = 1'b0;
      err_d     = err_q;
      nack_d    = nack_q;

      if (in_frame) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            clk_drv_d = 1'b0;
            dat_drv_d = 1'b0;
            if (accept) begin
               state_d   = ST_INHIBIT;
               shift_d   = ps2_frame_bits(tx_data);
               bit_idx_d = '0;
               inh_cnt_d = '0;
               to_cnt_d  = '0;
               nack_d    = 1'b0;
               clk_drv_d = 1'b1;
            end
         end
         ST_INHIBIT: begin
            if (inh_cnt_q == INHIBIT_LAST) begin
               state_d   = ST_START;
               dat_drv_d = 1'b1;   // start bit, clock still held low
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end
         ST_START: begin
            // Release the clock with data low: device begins clocking.
            clk_drv_d = 1'b0;
            to_cnt_d  = '0;
            state_d   = ST_BITS;
         end
         ST_BITS: begin
            if (clk_fall) begin
               dat_drv_d = ~shift_q[0];
               shift_d   = {1'b0, shift_q[8:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == PARITY_IDX) begin
                  state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (clk_fall) begin
               dat_drv_d = 1'b0;   // stop bit is the released (high) line
               state_d   = ST_ACK;
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               nack_d  = dat_level;
               state_d = ST_RECOVER;
            end
         end
         ST_RECOVER: begin
            if (clk_level && dat_level) begin
               done_d  = 1'b1;
               err_d   = nack_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            clk_drv_d = 1'b0;
            dat_drv_d = 1'b0;
         end
      endcase

      // Frame limit overrides any progress made this cycle.
      if (in_frame && (to_cnt_q == TIMEOUT_LAST)) begin
         state_d   = ST_IDLE;
         clk_drv_d = 1'b0;
         dat_drv_d = 1'b0;
         done_d    = 1'b1;
         err_d     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         inh_cnt_q <= '0;
         to_cnt_q  <= '0;
         clk_drv_q <= 1'b0;
         dat_drv_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         nack_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         inh_cnt_q <= inh_cnt_d;
         to_cnt_q  <= to_cnt_d;
         clk_drv_q <= clk_drv_d;
         dat_drv_q <= dat_drv_d;
         done_q    <= done_d;
         err_q     <= err_d;
         nack_q    <= nack_d;
      end
   end

   assign done            = done_q;
   assign err             = err_q;
   assign ps2_clk_drv_low = clk_drv_q;
   assign ps2_dat_drv_low = dat_drv_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 7500;
   localparam int TMO = 3000;
   localparam int FLT = 8;
   localparam int HP  = 30;   // device clock half-period in core cycles

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready, done, err, busy;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_drv_low, ps2_dat_drv_low;
   logic       dev_clk_low, dev_dat_low;

   always #5 clk = ~clk;

   // Open-drain wired-AND of host and device pull-downs.
   assign ps2_clk_in = ~(ps2_clk_drv_low | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_drv_low | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .FILTER_LEN     (FLT)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .tx_valid        (tx_valid),
      .tx_data         (tx_data),
      .tx_ready        (tx_ready),
      .done            (done),
      .err             (err),
      .busy            (busy),
      .ps2_clk_in      (ps2_clk_in),
      .ps2_dat_in      (ps2_dat_in),
      .ps2_clk_drv_low (ps2_clk_drv_low),
      .ps2_dat_drv_low (ps2_dat_drv_low)
   );

   typedef struct {
      logic [7:0] data;
      logic       err;
      logic       chk_data;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         accepts = 0;
   logic [7:0] got_byte;
   logic       got_par, got_stop;

   always @(posedge clk) begin
      if (reset && tx_valid && tx_ready) accepts++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Request a byte; the expected outcome is queued at the accept cycle.
   task automatic send(input logic [7:0] b, input logic exp_err, input logic chk_data,
                       input logic hold);
      int n;
      n = 0;
      tx_valid = 1'b1;
      tx_data  = b;
      while (tx_ready !== 1'b1 && n < 20000) begin
         tick();
         n++;
      end
      check("ready_wait", n < 20000, 1);
      sb.push_back('{b, exp_err, chk_data});
      tick();
      if (!hold) tx_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      check("clk_low_after_accept", ps2_clk_drv_low, 1);
   endtask

   task automatic wait_release(output int inh_cnt);
      int n;
      n = 0;
      inh_cnt = 0;
      while (!(ps2_clk_drv_low === 1'b0 && ps2_dat_drv_low === 1'b1) && n < 20000) begin
         if (ps2_clk_drv_low === 1'b1 && ps2_dat_drv_low === 1'b0) inh_cnt++;
         tick();
         n++;
      end
      check("release_wait", n < 20000, 1);
   endtask

   // Behavioural keyboard: clocks n_clocks bits, samples on each rising edge,
   // optionally pulls data low for the acknowledge clock.
   task automatic device_frame(input logic give_ack, input int n_clocks, output int inh_cnt);
      got_byte = '0;
      got_par  = 1'b0;
      got_stop = 1'b0;
      wait_release(inh_cnt);
      repeat (HP) tick();
      for (int k = 1; k <= n_clocks; k++) begin
         dev_clk_low = 1'b1;
         repeat (HP) tick();
         if (k <= 8) got_byte[k-1] = ps2_dat_in;
         else if (k == 9) got_par = ps2_dat_in;
         else if (k == 10) got_stop = ps2_dat_in;
         dev_clk_low = 1'b0;
         if (k == 10 && give_ack) dev_dat_low = 1'b1;
         if (k == 11) dev_dat_low = 1'b0;
         if (k < n_clocks) repeat (HP) tick();
      end
   endtask

   task automatic wait_done(input int budget, output int n);
      exp_t e;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check("done_seen", done, 1);
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("err_at_done", err, e.err);
         check("clk_released_at_done", ps2_clk_drv_low, 0);
         check("dat_released_at_done", ps2_dat_drv_low, 0);
         if (e.chk_data) begin
            check("rx_byte", got_byte, e.data);
            check("rx_parity", got_par, ~^e.data);
            check("rx_stop", got_stop, 1);
         end
         tick();
         check("done_one_cycle", done, 0);
         check("ready_after_done", tx_ready, 1);
         check("err_held", err, e.err);
      end
   endtask

   initial begin
      int inh, n, acc0;
      reset       = 1'b0;
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      repeat (3) tick();
      check("rst_tx_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_clk_drv", ps2_clk_drv_low, 0);
      check("rst_dat_drv", ps2_dat_drv_low, 0);
      reset = 1'b1;
      repeat (3) tick();

      // Set-LEDs command with acknowledge.
      send(CMD_SET_LEDS, 1'b0, 1'b1, 1'b0);
      device_frame(1'b1, 11, inh);
      check("inhibit_width_ed", inh, INH);
      wait_done(200, n);

      // All-zero byte: parity 1, exact inhibit width.
      send(8'h00, 1'b0, 1'b1, 1'b0);
      device_frame(1'b1, 11, inh);
      check("inhibit_width_00", inh, INH);
      wait_done(200, n);

      // Silent device: frame limit expires.
      send(8'h55, 1'b1, 1'b0, 1'b0);
      wait_release(inh);
      wait_done(TMO + 20, n);
      check("timeout_latency", n, TMO);

      // Device never acknowledges: err without waiting for the frame limit.
      send(CMD_ENABLE, 1'b1, 1'b1, 1'b0);
      device_frame(1'b0, 11, inh);
      wait_done(200, n);

      // Reset in the middle of bit 4 (bit3 of 0xA5 is 0, so data is pulled low).
      send(8'hA5, 1'b0, 1'b0, 1'b0);
      device_frame(1'b1, 4, inh);
      check("bit4_driven_low", ps2_dat_drv_low, 1);
      reset = 1'b0;
      #1;
      check("async_rst_clk_drv", ps2_clk_drv_low, 0);
      check("async_rst_dat_drv", ps2_dat_drv_low, 0);
      void'(sb.pop_back());
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      tick();
      reset = 1'b1;
      repeat (FLT + 4) tick();
      check("ready_after_rst", tx_ready, 1);
      check("busy_after_rst", busy, 0);
      send(CMD_RESET, 1'b0, 1'b1, 1'b0);
      device_frame(1'b1, 11, inh);
      wait_done(200, n);

      // tx_valid held across a frame with changing data: one frame per accept.
      acc0 = accepts;
      send(8'h11, 1'b0, 1'b1, 1'b1);
      tx_data = 8'h99;
      device_frame(1'b1, 11, inh);
      check("single_accept_in_flight", accepts - acc0, 1);
      tx_data = 8'h22;
      wait_done(200, n);
      send(8'h22, 1'b0, 1'b1, 1'b0);
      tx_data = 8'h33;
      device_frame(1'b1, 11, inh);
      wait_done(200, n);
      repeat (20) tick();
      check("idle_after_b2b", busy, 0);
      check("accept_count_b2b", accepts - acc0, 2);
      check("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
